reglk_enforcer: RTL and testbench
=================================

Name: reglk_enforcer

Overview:
Per-peripheral lock-enforcement stage directly downstream of the register-lock controller. Consumes one peripheral's 8-bit lock byte and sits between that peripheral's AXI-lite decoded request port (en/we/address/data) and its register bank. Gates reads and writes according to the lock byte. Snapshots the lock only at transaction boundaries. Logs blocked accesses in a saturating counter and a sticky interrupt.

Parameters:
ADDR_W, 8, request address width in bits; register index = addr[ADDR_W-1:3]
DATA_W, 64, request/response data width
CNT_W, 16, violation counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
lock_i  in  8  lock byte for this peripheral
req_valid_i  in  1  request valid from AXI-lite side
req_ready_o  out  1  request accepted
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_W  read data
rsp_err_o  out  1  access blocked (see Optional Feature)
per_en_o  out  1  peripheral strobe
per_we_o  out  1  peripheral write enable
per_addr_o  out  ADDR_W  peripheral address
per_wdata_o  out  DATA_W  peripheral write data
per_rdata_i  in  DATA_W  peripheral read data
per_ready_i  in  1  peripheral completes access this cycle
clr_i  in  1  clear violation log and IRQ
viol_cnt_o  out  CNT_W  blocked-access count, saturating
viol_addr_o  out  ADDR_W  address of first blocked access since clear
irq_o  out  1  sticky violation interrupt

Behaviour:
- Reset (async on rst_i high): state IDLE; lock_q=8'hFF (fully locked); all outputs 0; viol_cnt_o=0; viol_addr_o=0; irq_o=0.
- Lock rules, applied to lock_q:
  - bit0=1: all reads blocked.
  - bit3=1: writes to index 0 blocked.
  - bit1=1: writes to index >=1 blocked.
  - bits 7:4 and 2 are ignored.
- lock_q loads lock_i every cycle while state==IDLE, so a lock change takes effect one cycle after it appears. It is frozen in any other state.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: req_ready_o=1. On req_valid_i, latch we/addr/wdata and evaluate the rules against the current lock_q.
    - Allowed -> ISSUE.
    - Blocked -> RESP with rdata=0 and err set; the violation is logged; no per_en_o pulse.
  - ISSUE: per_en_o=1; per_we_o/addr/wdata come from the latch. Held until per_ready_i. In that cycle, capture per_rdata_i (reads only; writes return 0) -> RESP.
  - RESP: rsp_valid_o=1; rdata/err stable until rsp_ready_i -> IDLE. req_ready_o=0 outside IDLE.
- Latency, allowed access with per_ready_i=1 immediately: accept cycle N, per_en_o in N+1, rsp_valid_o in N+2. Blocked access: rsp_valid_o in N+1.
- Throughput: at most one outstanding transaction.
- Violation log:
  - Each blocked access increments viol_cnt_o, saturating at 2^CNT_W-1.
  - viol_addr_o captures the address only if viol_cnt_o==0 before the increment.
  - irq_o is set on any violation.
  - clr_i zeroes the count, address and IRQ. If clr_i coincides with a violation, the clear applies first and the violation is then logged: count=1, address captured, irq_o=1.
- Reset mid-transaction aborts immediately: per_en_o and rsp_valid_o drop asynchronously and no response is issued.

Optional Feature:
Macro REGLK_ERR_RESP_EN.
- Defined: rsp_err_o=1 in RESP for blocked accesses, 0 otherwise.
- Undefined: rsp_err_o is tied 0. Blocked accesses complete silently (reads return 0, writes dropped). Logging and IRQ are unchanged.

Test Plan:
- After reset with lock_i=8'h00, read index 2 -> rsp_rdata_o=0, err=1 (macro on), viol_cnt_o=1, irq_o=1; the 8'hFF lock snapshot holds until the first IDLE cycle.
- Hold lock_i=8'h00 for 2 cycles, write 64'hDEAD_BEEF to addr 0x10, per_ready_i=1 -> per_en_o=1 with per_addr_o=0x10 one cycle after accept; rsp_valid_o the next cycle; err=0.
- lock_i=8'h08: write addr 0x00 blocked (no per_en_o, count+1, viol_addr_o=0x00); write addr 0x08 passes; read addr 0x00 passes.
- lock_i changes 00->FF while in ISSUE with per_ready_i low for 3 cycles -> access completes unblocked; the next request is blocked.
- Force 2^16+5 blocked writes -> viol_cnt_o=16'hFFFF; viol_addr_o equals the first blocked address; clr_i coincident with a violation -> count=1, irq_o=1.
- Assert rst_i in ISSUE -> per_en_o=0 the same cycle; no rsp_valid_o after release; lock_q=8'hFF.

Source files
------------

// File: rtl/reglk_enforcer_if.sv
// Request/response bus between the AXI-lite decode stage and the lock
// enforcer. The field names carry the enforcer's view of direction.
//   master : the AXI-lite decode side (drives req_*_i, rsp_ready_i)
//   slave  : reglk_enforcer (drives req_ready_o, rsp_*_o)
// Parameters: ADDR_W byte-address width, DATA_W data width.
interface reglk_enforcer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/reglk_enforcer.sv
// Per-peripheral lock enforcement between an AXI-lite decoded request port
// and the peripheral register bank. Reads/writes are gated by a snapshot of
// the lock byte taken only while idle; blocked accesses are answered locally
// (read data 0), counted in a saturating counter, and raise a sticky IRQ.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   lock_i            lock byte (bit0 reads, bit3 writes idx0, bit1 writes idx>=1)
//   bus (slave)       req valid/ready/we/addr/wdata, rsp valid/ready/rdata/err
//   per_*             peripheral strobe, write enable, address, data, ready
//   clr_i             clears violation count, first address and IRQ
//   viol_cnt_o        saturating blocked-access count
//   viol_addr_o       address of the first blocked access since clear
//   irq_o             sticky violation interrupt
//
// Build option: define REGLK_ERR_RESP_EN to report blocked accesses on
// rsp_err_o; otherwise rsp_err_o is tied low and blocked accesses complete
// silently.
module reglk_enforcer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        lock_i,
  reglk_enforcer_if.slave   bus,
  output logic              per_en_o,
  output logic              per_we_o,
  output logic [ADDR_W-1:0] per_addr_o,
  output logic [DATA_W-1:0] per_wdata_o,
  input  logic [DATA_W-1:0] per_rdata_i,
  input  logic              per_ready_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  viol_cnt_o,
  output logic [ADDR_W-1:0] viol_addr_o,
  output logic              irq_o
);

  localparam int unsigned IDX_W = ADDR_W - 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [7:0]        lock_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [IDX_W-1:0]  req_idx_c;
  logic              blocked_c;
  logic              accept_c;
  logic              viol_c;
  logic [CNT_W-1:0]  cnt_base_c;
  logic              unused_lock_c;

  // Only bits 0, 1 and 3 of the lock byte carry meaning.
  assign unused_lock_c = ^{lock_q[7:4], lock_q[2]};

  assign req_idx_c = bus.req_addr_i[ADDR_W-1:3];
  assign accept_c  = (state_q == ST_IDLE) && bus.req_valid_i;
  assign viol_c    = accept_c && blocked_c;

  // Lock rules evaluated against the idle-time snapshot, never lock_i directly.
  always_comb begin
    blocked_c = 1'b0;
    if (!bus.req_we_i) begin
      blocked_c = lock_q[0];
    end else if (req_idx_c == '0) begin
      blocked_c = lock_q[3];
    end else begin
      blocked_c = lock_q[1];
    end
  end

  // Ready is a decode of the state register so that a request presented in
  // the very first cycle after reset is taken against the reset snapshot
  // (fully locked); it is held low while reset is asserted.
  assign bus.req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

  // Transaction FSM: lock snapshot, peripheral issue and response hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lock_q      <= 8'hFF;
      per_en_o    <= 1'b0;
      per_we_o    <= 1'b0;
      per_addr_o  <= '0;
      per_wdata_o <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lock_q <= lock_i;
          if (bus.req_valid_i) begin
            if (blocked_c) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ST_ISSUE;
              per_en_o    <= 1'b1;
              per_we_o    <= bus.req_we_i;
              per_addr_o  <= bus.req_addr_i;
              per_wdata_o <= bus.req_wdata_i;
            end
          end
        end
        ST_ISSUE: begin
          if (per_ready_i) begin
            state_q     <= ST_RESP;
            per_en_o    <= 1'b0;
            rsp_valid_q <= 1'b1;
            // per_we_o still holds the latched direction of this access.
            rsp_rdata_q <= per_we_o ? '0 : per_rdata_i;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REGLK_ERR_RESP_EN
  logic rsp_err_q;

  // Error flag is meaningful only while the response is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (accept_c) begin
      rsp_err_q <= blocked_c;
    end else if ((state_q == ST_RESP) && bus.rsp_ready_i) begin
      rsp_err_q <= 1'b0;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  assign bus.rsp_err_o = 1'b0;
`endif

  // A clear coinciding with a violation acts first, so that violation
  // becomes the first one logged.
  assign cnt_base_c = clr_i ? '0 : viol_cnt_o;

  // Violation log: saturating count, first blocked address, sticky IRQ.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      viol_cnt_o  <= '0;
      viol_addr_o <= '0;
      irq_o       <= 1'b0;
    end else if (viol_c) begin
      if (cnt_base_c != CNT_MAX) begin
        viol_cnt_o <= cnt_base_c + CNT_W'(1);
      end else begin
        viol_cnt_o <= cnt_base_c;
      end
      if (cnt_base_c == '0) begin
        viol_addr_o <= bus.req_addr_i;
      end else if (clr_i) begin
        viol_addr_o <= '0;
      end
      irq_o <= 1'b1;
    end else if (clr_i) begin
      viol_cnt_o  <= '0;
      viol_addr_o <= '0;
      irq_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reglk_enforcer.sv
// Self-checking bench for reglk_enforcer: directed scenarios plus randomized
// transactions against a transaction-level model (lock snapshot, memory
// image of the register bank, violation log).
module tb_reglk_enforcer;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef REGLK_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [7:0]        lock_i;
  logic              per_en_o, per_we_o;
  logic [ADDR_W-1:0] per_addr_o;
  logic [DATA_W-1:0] per_wdata_o, per_rdata_i;
  logic              per_ready_i, clr_i;
  logic [CNT_W-1:0]  viol_cnt_o;
  logic [ADDR_W-1:0] viol_addr_o;
  logic              irq_o;

  reglk_enforcer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reglk_enforcer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lock_i(lock_i), .bus(bus),
    .per_en_o(per_en_o), .per_we_o(per_we_o), .per_addr_o(per_addr_o),
    .per_wdata_o(per_wdata_o), .per_rdata_i(per_rdata_i),
    .per_ready_i(per_ready_i), .clr_i(clr_i), .viol_cnt_o(viol_cnt_o),
    .viol_addr_o(viol_addr_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state
  logic [7:0]  m_lock;
  int          m_cnt;
  logic [7:0]  m_vaddr;
  bit          m_irq;
  logic [63:0] mem [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rule_blocks(input logic [7:0] lk, input bit we, input logic [7:0] a);
    if (!we) return lk[0];
    if (a[7:3] == 5'd0) return lk[3];
    return lk[1];
  endfunction

  task automatic log_event(input bit clr, input bit viol, input logic [7:0] a);
    if (clr) begin m_cnt = 0; m_vaddr = 8'h00; m_irq = 1'b0; end
    if (viol) begin
      if (m_cnt == 0) m_vaddr = a;
      if (m_cnt < CNT_MAX) m_cnt++;
      m_irq = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_lock = 8'hFF; m_cnt = 0; m_vaddr = 8'h00; m_irq = 1'b0;
  endtask

  // One clock with the DUT idle: it samples the lock byte.
  task automatic idle_cycle();
    @(negedge clk_i);
    m_lock = lock_i;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, ".viol_cnt"}, 64'(viol_cnt_o), 64'(m_cnt));
    chk({tag, ".viol_addr"}, 64'(viol_addr_o), 64'(m_vaddr));
    chk({tag, ".irq"}, 64'(irq_o), 64'(m_irq));
  endtask

  // Full transaction starting and ending at a negedge with the DUT idle.
  task automatic txn(input string tag, input bit we, input logic [7:0] a,
                     input logic [63:0] wd, input int pre_idle, input int per_dly,
                     input int rsp_dly, input bit clr, input bit mid_en,
                     input logic [7:0] mid_lock);
    bit blk;
    logic [63:0] exp_rd;
    for (int i = 0; i < pre_idle; i++) idle_cycle();
    chk({tag, ".ready"}, 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a;
    bus.req_wdata_i = wd; clr_i = clr;
    @(negedge clk_i);
    blk = rule_blocks(m_lock, we, a);
    m_lock = lock_i;
    log_event(clr, blk, a);
    bus.req_valid_i = 1'b0; clr_i = 1'b0;
    bus.req_addr_i = 8'($urandom); bus.req_wdata_i = {$urandom, $urandom};
    if (mid_en) lock_i = mid_lock;
    chk({tag, ".per_en"}, 64'(per_en_o), 64'(!blk));
    chk({tag, ".busy_ready"}, 64'(bus.req_ready_o), 64'd0);
    exp_rd = 64'd0;
    if (!blk) begin
      chk({tag, ".per_we"}, 64'(per_we_o), 64'(we));
      chk({tag, ".per_addr"}, 64'(per_addr_o), 64'(a));
      if (we) chk({tag, ".per_wdata"}, per_wdata_o, wd);
      for (int i = 0; i < per_dly; i++) begin
        per_ready_i = 1'b0; per_rdata_i = {$urandom, $urandom};
        @(negedge clk_i);
        chk({tag, ".per_en_hold"}, 64'(per_en_o), 64'd1);
        chk({tag, ".early_rsp"}, 64'(bus.rsp_valid_o), 64'd0);
      end
      per_ready_i = 1'b1; per_rdata_i = mem[a[7:3]];
      if (!we) exp_rd = mem[a[7:3]];
      @(negedge clk_i);
      per_ready_i = 1'b0; per_rdata_i = {$urandom, $urandom};
      if (we) mem[a[7:3]] = wd;
      chk({tag, ".per_en_drop"}, 64'(per_en_o), 64'd0);
    end
    chk_log(tag);
    for (int i = 0; i <= rsp_dly; i++) begin
      chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
      chk({tag, ".rsp_rdata"}, bus.rsp_rdata_o, exp_rd);
      chk({tag, ".rsp_err"}, 64'(bus.rsp_err_o), 64'(ERR_EN & blk));
      if (i < rsp_dly) @(negedge clk_i);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    chk({tag, ".rsp_done"}, 64'(bus.rsp_valid_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lk_tab [7];
    logic [7:0] first_a;
    int n, cyc;
    lk_tab = '{8'h00, 8'h08, 8'h02, 8'h01, 8'h0A, 8'hFF, 8'hF4};
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};

    // Reset values
    rst_i = 1'b1; lock_i = 8'h00; clr_i = 1'b0; per_ready_i = 1'b0;
    per_rdata_i = '0; bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.rsp_ready_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst.ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst.per_en", 64'(per_en_o), 64'd0);
    chk("rst.per_addr", 64'(per_addr_o), 64'd0);
    chk("rst.rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata_o, 64'd0);
    chk("rst.rsp_err", 64'(bus.rsp_err_o), 64'd0);
    chk_log("rst");
    rst_i = 1'b0; #1;

    // First request after reset sees the fully-locked snapshot
    txn("t1_rd_after_rst", 1'b0, 8'h10, 64'd0, 0, 0, 0, 1'b0, 1'b0, 8'h00);
    // Unlocked write
    txn("t2_wr_unlocked", 1'b1, 8'h10, 64'hDEAD_BEEF, 2, 0, 0, 1'b0, 1'b0, 8'h00);
    txn("t2_rd_back", 1'b0, 8'h10, 64'd0, 0, 1, 1, 1'b0, 1'b0, 8'h00);
    // Lock 08: only index-0 writes blocked
    lock_i = 8'h08;
    txn("t3_wr_idx0", 1'b1, 8'h00, 64'h1234, 1, 0, 0, 1'b1, 1'b0, 8'h00);
    txn("t3_wr_idx1", 1'b1, 8'h08, 64'h5678, 0, 0, 0, 1'b0, 1'b0, 8'h00);
    txn("t3_rd_idx0", 1'b0, 8'h00, 64'd0, 0, 0, 0, 1'b0, 1'b0, 8'h00);
    // Lock rises while in ISSUE: current access completes, next is blocked
    lock_i = 8'h00;
    txn("t4_mid_lock", 1'b1, 8'h18, 64'hCAFE, 1, 3, 0, 1'b0, 1'b1, 8'hFF);
    txn("t4_after", 1'b0, 8'h18, 64'd0, 1, 0, 0, 1'b0, 1'b0, 8'h00);

    // Randomized transactions
    for (int k = 0; k < 150; k++) begin
      lock_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : lk_tab[$urandom_range(0, 6)];
      txn("rand", 1'($urandom), 8'($urandom), {$urandom, $urandom},
          $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    // Counter saturation with back-to-back blocked writes
    lock_i = 8'hFF;
    idle_cycle();
    clr_i = 1'b1; idle_cycle(); clr_i = 1'b0; log_event(1'b1, 1'b0, 8'h00);
    chk_log("clr_idle");
    first_a = 8'h28;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = first_a;
    bus.rsp_ready_i = 1'b1;
    n = 0; cyc = 0;
    while (n < CNT_MAX + 6 && cyc < 5000) begin
      if (bus.req_ready_o) begin
        log_event(1'b0, 1'b1, bus.req_addr_i);
        n++;
      end
      @(negedge clk_i);
      cyc++;
      bus.req_addr_i = 8'($urandom);
    end
    chk("sat.accepts", 64'(n), 64'(CNT_MAX + 6));
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    chk("sat.model_cnt", 64'(viol_cnt_o), 64'(CNT_MAX));
    chk("sat.first_addr", 64'(viol_addr_o), 64'(first_a));
    chk_log("sat");
    chk("sat.idle", 64'(bus.req_ready_o), 64'd1);

    // Clear coinciding with a violation
    txn("clr_viol", 1'b1, 8'h30, 64'h77, 0, 0, 0, 1'b1, 1'b0, 8'h00);
    chk("clr_viol.cnt_is_1", 64'(viol_cnt_o), 64'd1);

    // Reset while in ISSUE
    lock_i = 8'h00;
    idle_cycle(); idle_cycle();
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 8'h20;
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    chk("rst_mid.issue", 64'(per_en_o), 64'd1);
    rst_i = 1'b1; #1;
    chk("rst_mid.per_en_async", 64'(per_en_o), 64'd0);
    chk("rst_mid.rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0; #1;
    chk("rst_mid.no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    chk_log("rst_mid");
    txn("rst_mid.locked", 1'b0, 8'h10, 64'd0, 0, 0, 0, 1'b0, 1'b0, 8'h00);
    txn("rst_mid.unlocked", 1'b0, 8'h10, 64'd0, 1, 0, 0, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
